// File: rtl/i2c_target.sv
// I2C target: address match, 8-bit register pointer, auto-incrementing register-file reads/writes.
// Latency: about 5 i_clk cycles from a bus pin change to the FSM reacting (2 sync stages, FILT_LEN filter, edge register).
// Backpressure: none. SCL is never stretched, and i_rd_data must be valid on the i_clk edge after o_rd_req.
//
// Ports:
//   i_clk, i_rst_n     system clock and synchronous active-low reset
//   i_dev_addr         own 7-bit address, latched at every START
//   i2c_scl, i2c_sda   bus pins; SDA is open-drain and only ever pulled low
//   o_reg_addr         register pointer
//   o_wr_en/o_wr_data  one-cycle write strobe and its data
//   o_rd_req/i_rd_data one-cycle read request and the data returned for it
//   o_sda_oe           SDA pull-low enable; o_busy marks an addressed transfer; o_sm is the state
module i2c_target #(
   parameter int FILT_LEN = 3   // must be >= 2
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic [6:0] i_dev_addr,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   output logic [7:0] o_reg_addr,
   output logic       o_wr_en,
   output logic [7:0] o_wr_data,
   output logic       o_rd_req,
   input  logic [7:0] i_rd_data,
   output logic       o_sda_oe,
   output logic       o_busy,
   output logic [3:0] o_sm
);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_ADDR      = 4'd1,
      S_ADDR_ACK  = 4'd2,
      S_PTR       = 4'd3,
      S_PTR_ACK   = 4'd4,
      S_WDATA     = 4'd5,
      S_WDATA_ACK = 4'd6,
      S_RDATA     = 4'd7,
      S_RACK      = 4'd8,
      S_IGNORE    = 4'd9
   } state_t;

   logic [1:0]          r_scl_sync, r_sda_sync;
   logic [FILT_LEN-1:0] r_scl_hist, r_sda_hist;
   logic                r_scl_f, r_sda_f, r_scl_fd, r_sda_fd;

   state_t      r_state;
   logic [3:0]  r_bitcnt;
   logic [6:0]  r_shift;
   logic [6:0]  r_dev;
   logic        r_rw;
   logic        r_ack_drv;   // ACK currently driven; the next SCL fall ends it
   logic [7:0]  r_rd_shift;
   logic        r_rd_pend;   // issues o_rd_req one cycle after a read-ACK increment
   logic        r_inc;       // pointer increment one cycle after o_wr_en
   logic [7:0]  r_reg_addr;
   logic        r_wr_en;
   logic [7:0]  r_wr_data;
   logic        r_rd_req;
   logic        r_sda_oe;
   logic        r_busy;

   logic       w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;
   logic [7:0] w_byte;

   assign i2c_sda = r_sda_oe ? 1'b0 : 1'bz;

   // Sync plus glitch filter. The filtered value only moves once the whole history agrees.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_scl_sync <= 2'b11;
         r_sda_sync <= 2'b11;
         r_scl_hist <= '1;
         r_sda_hist <= '1;
         r_scl_f    <= 1'b1;
         r_sda_f    <= 1'b1;
         r_scl_fd   <= 1'b1;
         r_sda_fd   <= 1'b1;
      end else begin
         r_scl_sync <= {r_scl_sync[0], i2c_scl};
         r_sda_sync <= {r_sda_sync[0], i2c_sda};
         r_scl_hist <= {r_scl_hist[FILT_LEN-2:0], r_scl_sync[1]};
         r_sda_hist <= {r_sda_hist[FILT_LEN-2:0], r_sda_sync[1]};
         if (&r_scl_hist)       r_scl_f <= 1'b1;
         else if (~|r_scl_hist) r_scl_f <= 1'b0;
         if (&r_sda_hist)       r_sda_f <= 1'b1;
         else if (~|r_sda_hist) r_sda_f <= 1'b0;
         r_scl_fd <= r_scl_f;
         r_sda_fd <= r_sda_f;
      end
   end

   assign w_scl_rise = r_scl_f & ~r_scl_fd;
   assign w_scl_fall = ~r_scl_f & r_scl_fd;
   assign w_sda_rise = r_sda_f & ~r_sda_fd;
   assign w_sda_fall = ~r_sda_f & r_sda_fd;
   assign w_start    = w_sda_fall & r_scl_f;
   assign w_stop     = w_sda_rise & r_scl_f;
   assign w_byte     = {r_shift, r_sda_f};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_bitcnt   <= '0;
         r_shift    <= '0;
         r_dev      <= '0;
         r_rw       <= 1'b0;
         r_ack_drv  <= 1'b0;
         r_rd_shift <= '0;
         r_rd_pend  <= 1'b0;
         r_inc      <= 1'b0;
         r_reg_addr <= '0;
         r_wr_en    <= 1'b0;
         r_wr_data  <= '0;
         r_rd_req   <= 1'b0;
         r_sda_oe   <= 1'b0;
         r_busy     <= 1'b0;
      end else begin
         r_wr_en   <= 1'b0;
         r_rd_req  <= r_rd_pend;
         r_rd_pend <= 1'b0;
         r_inc     <= 1'b0;
         if (r_inc)    r_reg_addr <= r_reg_addr + 8'd1;
         if (r_rd_req) r_rd_shift <= i_rd_data;

         // Bus conditions take priority over any data edge.
         if (w_start) begin
            r_state   <= S_ADDR;
            r_bitcnt  <= '0;
            r_sda_oe  <= 1'b0;
            r_ack_drv <= 1'b0;
            r_dev     <= i_dev_addr;
         end else if (w_stop) begin
            r_state   <= S_IDLE;
            r_sda_oe  <= 1'b0;
            r_busy    <= 1'b0;
            r_ack_drv <= 1'b0;
         end else begin
            case (r_state)
               S_ADDR, S_PTR, S_WDATA: begin
                  if (w_scl_rise) begin
                     r_shift <= w_byte[6:0];
                     if (r_bitcnt == 4'd7) begin
                        r_bitcnt <= '0;
                        if (r_state == S_ADDR) begin
                           if (w_byte[7:1] == r_dev) begin
                              r_rw     <= w_byte[0];
                              r_rd_req <= w_byte[0];
                              r_state  <= S_ADDR_ACK;
                           end else begin
                              r_state  <= S_IGNORE;
                           end
                        end else if (r_state == S_PTR) begin
                           r_reg_addr <= w_byte;
                           r_state    <= S_PTR_ACK;
                        end else begin
                           r_wr_data <= w_byte;
                           r_wr_en   <= 1'b1;
                           r_inc     <= 1'b1;
                           r_state   <= S_WDATA_ACK;
                        end
                     end else begin
                        r_bitcnt <= r_bitcnt + 4'd1;
                     end
                  end
               end
               S_ADDR_ACK, S_PTR_ACK, S_WDATA_ACK: begin
                  // First SCL fall starts the ACK. The second ends it and hands SDA to the next phase.
                  if (w_scl_fall) begin
                     if (!r_ack_drv) begin
                        r_ack_drv <= 1'b1;
                        r_sda_oe  <= 1'b1;
                        r_busy    <= 1'b1;
                     end else begin
                        r_ack_drv <= 1'b0;
                        r_sda_oe  <= 1'b0;
                        r_bitcnt  <= '0;
                        if (r_state == S_ADDR_ACK && r_rw) begin
                           r_state    <= S_RDATA;
                           r_sda_oe   <= ~r_rd_shift[7];
                           r_rd_shift <= {r_rd_shift[6:0], 1'b0};
                           r_bitcnt   <= 4'd1;
                        end else if (r_state == S_ADDR_ACK) begin
                           r_state <= S_PTR;
                        end else begin
                           r_state <= S_WDATA;
                        end
                     end
                  end
               end
               S_RDATA: begin
                  // r_bitcnt counts the bits already presented.
                  if (w_scl_fall) begin
                     if (r_bitcnt == 4'd8) begin
                        r_sda_oe <= 1'b0;
                        r_state  <= S_RACK;
                     end else begin
                        r_sda_oe   <= ~r_rd_shift[7];
                        r_rd_shift <= {r_rd_shift[6:0], 1'b0};
                        r_bitcnt   <= r_bitcnt + 4'd1;
                     end
                  end
               end
               S_RACK: begin
                  if (w_scl_rise) begin
                     if (!r_sda_f) begin
                        r_reg_addr <= r_reg_addr + 8'd1;
                        r_rd_pend  <= 1'b1;
                        r_bitcnt   <= '0;
                        r_state    <= S_RDATA;
                     end else begin
                        r_state <= S_IGNORE;
                     end
                  end
               end
               S_IDLE, S_IGNORE: ;
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign o_reg_addr = r_reg_addr;
   assign o_wr_en    = r_wr_en;
   assign o_wr_data  = r_wr_data;
   assign o_rd_req   = r_rd_req;
   assign o_sda_oe   = r_sda_oe;
   assign o_busy     = r_busy;
   assign o_sm       = r_state;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-banged I2C master with a write-vector table plus hand sequences.
// Latency: expected register-bus events are queued at stimulus time and popped when the DUT strobes.
// Backpressure: none; every wait on the DUT is cycle-bounded.
module tb_i2c_target;

   localparam int Q = 10;   // quarter SCL period in i_clk cycles

   typedef struct {
      logic [7:0] ptr;
      logic [7:0] d0;
      logic [7:0] d1;
      logic [7:0] exp_end;   // pointer expected after STOP
   } wvec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl = 1'b1;
   logic       m_low = 1'b0;
   wire        sda;
   logic [6:0] dev_addr = 7'h48;
   logic [7:0] reg_addr, wr_data, rd_data;
   logic       wr_en, rd_req, sda_oe, busy;
   logic [3:0] sm;

   int checks = 0;
   int failures = 0;
   int oe_cnt = 0, wr_cnt = 0, rd_cnt = 0;
   logic [15:0] wr_q[$];
   logic [7:0]  rd_q[$];
   wvec_t wtab[4];

   assign sda = m_low ? 1'b0 : 1'bz;
   pullup (sda);
   assign rd_data = reg_addr ^ 8'hFF;   // register file model

   always #5 clk = ~clk;

   i2c_target #(.FILT_LEN(3)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_dev_addr(dev_addr),
      .i2c_scl(scl), .i2c_sda(sda),
      .o_reg_addr(reg_addr), .o_wr_en(wr_en), .o_wr_data(wr_data),
      .o_rd_req(rd_req), .i_rd_data(rd_data),
      .o_sda_oe(sda_oe), .o_busy(busy), .o_sm(sm)
   );

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard side: pop expected register-bus events when the DUT strobes.
   always @(negedge clk) begin
      if (sda_oe) oe_cnt++;
      if (wr_en) begin
         wr_cnt++;
         chk("wr_event_expected", (wr_q.size() > 0) ? 1 : 0, 1);
         if (wr_q.size() > 0) chk("wr_addr_data", {reg_addr, wr_data}, wr_q.pop_front());
      end
      if (rd_req) begin
         rd_cnt++;
         chk("rd_event_expected", (rd_q.size() > 0) ? 1 : 0, 1);
         if (rd_q.size() > 0) chk("rd_req_addr", reg_addr, rd_q.pop_front());
      end
   end

   task automatic wq(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Works from idle and as a repeated START from SCL low.
   task automatic m_start();
      m_low = 1'b0; wq(Q);
      scl = 1'b1;   wq(Q);
      m_low = 1'b1; wq(Q);
      scl = 1'b0;   wq(Q);
   endtask

   task automatic m_stop();
      m_low = 1'b1; wq(Q);
      scl = 1'b1;   wq(Q);
      m_low = 1'b0; wq(Q);
   endtask

   // glitch: 1 = one-cycle SDA flip while SCL high, 2 = one-cycle SCL pulse while SCL low
   task automatic m_bit(input logic b, input int glitch, output logic s);
      m_low = ~b; wq(Q);
      if (glitch == 2) begin scl = 1'b1; wq(1); scl = 1'b0; end
      scl = 1'b1; wq(Q);
      s = (sda === 1'b0) ? 1'b0 : 1'b1;
      if (glitch == 1) begin m_low = b; wq(1); m_low = ~b; end
      wq(Q);
      scl = 1'b0; wq(Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input logic gl, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--)
         m_bit(b[i], !gl ? 0 : (i == 3) ? 1 : (i == 5) ? 2 : 0, s);
      m_bit(1'b1, 0, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic mack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         m_bit(1'b1, 0, s);
         d[i] = s;
      end
      m_bit(~mack, 0, s);
   endtask

   task automatic do_write(input wvec_t v, input logic gl);
      logic ack;
      wr_q.push_back({v.ptr, v.d0});
      wr_q.push_back({v.ptr + 8'd1, v.d1});
      m_start();
      wr_byte(8'h90, 1'b0, ack); chk("wr_addr_ack", ack, 1);
      chk("busy_after_ack", busy, 1);
      wr_byte(v.ptr, 1'b0, ack); chk("wr_ptr_ack", ack, 1);
      wr_byte(v.d0, gl, ack);    chk("wr_d0_ack", ack, 1);
      wr_byte(v.d1, 1'b0, ack);  chk("wr_d1_ack", ack, 1);
      m_stop(); wq(8);
      chk("end_reg_addr", reg_addr, v.exp_end);
      chk("busy_after_stop", busy, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic       ack, s;
      logic [7:0] d;
      int         w0, r0, o0, n;

      wtab[0] = '{ptr: 8'h10, d0: 8'hA5, d1: 8'h5A, exp_end: 8'h12};
      wtab[1] = '{ptr: 8'hFF, d0: 8'h11, d1: 8'h22, exp_end: 8'h01};
      wtab[2] = '{ptr: 8'h00, d0: 8'h3C, d1: 8'hC3, exp_end: 8'h02};
      wtab[3] = '{ptr: 8'h7E, d0: 8'h00, d1: 8'hFF, exp_end: 8'h80};

      // Reset state
      wq(5);
      chk("rst_sm", sm, 0);
      chk("rst_reg_addr", reg_addr, 0);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_rd_req", rd_req, 0);
      chk("rst_sda_oe", sda_oe, 0);
      chk("rst_busy", busy, 0);
      rst_n = 1'b1;
      wq(10);

      // Table-driven writes, including the 0xFF -> 0x00 pointer wrap
      for (int i = 0; i < 4; i++) do_write(wtab[i], 1'b0);

      // Pointer write, repeated START, two-byte read (ACK then NACK)
      rd_q.push_back(8'h20);
      rd_q.push_back(8'h21);
      m_start();
      wr_byte(8'h90, 1'b0, ack); chk("rd_waddr_ack", ack, 1);
      wr_byte(8'h20, 1'b0, ack); chk("rd_ptr_ack", ack, 1);
      m_start();
      wr_byte(8'h91, 1'b0, ack); chk("rd_raddr_ack", ack, 1);
      rd_byte(1'b1, d); chk("rd_byte0", d, 8'hDF);
      rd_byte(1'b0, d); chk("rd_byte1", d, 8'hDE);
      chk("rd_nack_ignore", sm, 9);
      m_stop(); wq(8);
      chk("rd_end_reg_addr", reg_addr, 8'h21);
      chk("rd_busy_after_stop", busy, 0);

      // Address mismatch: nothing acknowledged or issued
      w0 = wr_cnt; r0 = rd_cnt; o0 = oe_cnt;
      m_start();
      wr_byte(8'h92, 1'b0, ack); chk("mis_addr_ack", ack, 0);
      chk("mis_sm_ignore", sm, 9);
      chk("mis_busy", busy, 0);
      wr_byte(8'h10, 1'b0, ack); chk("mis_byte_ack", ack, 0);
      m_stop(); wq(8);
      chk("mis_sda_oe_cycles", oe_cnt - o0, 0);
      chk("mis_wr_cnt", wr_cnt - w0, 0);
      chk("mis_rd_cnt", rd_cnt - r0, 0);

      // STOP mid data byte aborts without a write
      w0 = wr_cnt;
      m_start();
      wr_byte(8'h90, 1'b0, ack); chk("abort_addr_ack", ack, 1);
      wr_byte(8'h40, 1'b0, ack); chk("abort_ptr_ack", ack, 1);
      for (int i = 0; i < 4; i++) m_bit(1'b1, 0, s);
      m_stop(); wq(8);
      chk("abort_wr_cnt", wr_cnt - w0, 0);
      chk("abort_reg_addr", reg_addr, 8'h40);
      chk("abort_sm_idle", sm, 0);

      // One-cycle glitches in IDLE
      m_low = 1'b1; wq(1); m_low = 1'b0; wq(20);
      chk("glitch_sda_idle_sm", sm, 0);
      scl = 1'b0; wq(1); scl = 1'b1; wq(20);
      chk("glitch_scl_idle_sm", sm, 0);
      chk("glitch_idle_busy", busy, 0);

      // One-cycle glitches inside a data byte
      do_write(wtab[0], 1'b1);

      // Reset while the address ACK is being driven
      m_start();
      for (int i = 7; i >= 0; i--) m_bit(d_addr_bit(i), 0, s);
      m_low = 1'b0;
      n = 0;
      while (!sda_oe && n < 4 * Q) begin wq(1); n++; end
      chk("rst_ack_driven", sda_oe, 1);
      rst_n = 1'b0; wq(1);
      chk("rst_mid_sda_oe", sda_oe, 0);
      chk("rst_mid_sm", sm, 0);
      scl = 1'b1; wq(5);
      rst_n = 1'b1; wq(10);
      do_write(wtab[2], 1'b0);

      wq(10);
      chk("wr_q_drained", wr_q.size(), 0);
      chk("rd_q_drained", rd_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bits of the write address 0x90 (7'h48, rw=0)
   function automatic logic d_addr_bit(input int i);
      logic [7:0] a;
      a = 8'h90;
      return a[i];
   endfunction

endmodule
